// File: rtl/wam_display_pkg.sv
// rtl/wam_display_pkg.sv - shared constants, state type and elaboration helpers for the decimal display
package wam_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } disp_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - one decimal digit to active-low gfedcba segment code
module seg7_encode
  import wam_display_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_DIGIT[0];
      4'd1: o_seg = SEG_DIGIT[1];
      4'd2: o_seg = SEG_DIGIT[2];
      4'd3: o_seg = SEG_DIGIT[3];
      4'd4: o_seg = SEG_DIGIT[4];
      4'd5: o_seg = SEG_DIGIT[5];
      4'd6: o_seg = SEG_DIGIT[6];
      4'd7: o_seg = SEG_DIGIT[7];
      4'd8: o_seg = SEG_DIGIT[8];
      4'd9: o_seg = SEG_DIGIT[9];
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_display.sv
// rtl/multi_digit_display.sv - sequential binary-to-decimal converter driving DIGITS 7-segment displays
module multi_digit_display
  import wam_display_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_load,
  input  logic                  i_enable,
  input  logic                  i_blank_lz,
  input  logic                  i_blink,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_hex
);

  // Scratch holds enough BCD nibbles for any WIDTH-bit value (at most one digit per 3 bits).
  localparam int SCR_N = max_int(DIGITS, (WIDTH + 2) / 3);
  localparam int SW    = 4 * SCR_N;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BW    = $clog2(BLINK_DIV);
  localparam int CW    = (WIDTH > 40) ? WIDTH : 40;
  localparam logic [CW-1:0] LIMIT = CW'(pow10(DIGITS));

  disp_state_t         r_state;
  disp_state_t         w_next;
  logic [WIDTH-1:0]    r_shift;
  logic [SW-1:0]       r_scratch;
  logic [SW-1:0]       w_adj;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [4*DIGITS-1:0] r_digits;
  logic                r_overflow;
  logic                r_done;
  logic                r_phase;
  logic [BW-1:0]       r_blink_cnt;
  logic [DIGITS-1:0]   w_show;
  logic                w_seen;
  logic [7*DIGITS-1:0] w_seg;
  logic [CW-1:0]       w_val_ext;

  assign w_val_ext  = CW'(r_shift);
  assign o_done     = r_done;
  assign o_overflow = r_overflow;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load) w_next = CONVERT;
      end
      CONVERT: begin
        o_busy = 1'b1;
        if (r_bit_cnt == CNT_W'(WIDTH - 1)) w_next = UPDATE;
      end
      UPDATE: begin
        o_busy = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_scratch;
    for (int n = 0; n < SCR_N; n++) begin
      if (r_scratch[4*n +: 4] >= 4'd5) w_adj[4*n +: 4] = r_scratch[4*n +: 4] + 4'd3;
    end
  end

  // The shift register rotates so the captured value is intact again for the overflow compare.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_bit_cnt  <= '0;
      r_digits   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_shift   <= i_value;
            r_scratch <= '0;
            r_bit_cnt <= '0;
          end
        end
        CONVERT: begin
          r_scratch <= {w_adj[SW-2:0], r_shift[WIDTH-1]};
          r_shift   <= (r_shift << 1) | (r_shift >> (WIDTH - 1));
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
        UPDATE: begin
          r_digits   <= r_scratch[4*DIGITS-1:0];
          r_overflow <= (w_val_ext >= LIMIT);
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || !i_blink) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  always_comb begin
    w_seen = 1'b0;
    w_show = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_seen    = w_seen | (r_digits[4*k +: 4] != 4'd0);
      w_show[k] = !i_blank_lz || (k == 0) || w_seen;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .i_digit (r_digits[4*g +: 4]),
      .o_seg   (w_seg[7*g +: 7])
    );
  end

  always_comb begin
    o_hex = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (!i_enable || (i_blink && r_phase)) o_hex[7*k +: 7] = SEG_BLANK;
      else if (r_overflow)                   o_hex[7*k +: 7] = SEG_DASH;
      else if (!w_show[k])                   o_hex[7*k +: 7] = SEG_BLANK;
      else                                   o_hex[7*k +: 7] = w_seg[7*k +: 7];
    end
  end

endmodule
